// File: rtl/irq_exc_ctrl_pkg.sv
// Shared types and helpers for the interrupt/exception controller and its context stack.
package irq_exc_ctrl_pkg;

    localparam int CAUSE_W = 4;
    localparam int PRI_W   = 4;
    localparam int PC_W    = 32;

    localparam logic [2:0] OVF   = 3'd1;
    localparam logic [2:0] DIVZ  = 3'd2;
    localparam logic [2:0] BRK   = 3'd3;
    localparam logic [2:0] UNDEF = 3'd4;

    typedef enum logic {
        RUN   = 1'b0,
        REDIR = 1'b1
    } ctrl_state_t;

    // pc is stored at full PC_W width; narrower ADDR_W values are zero-extended.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [CAUSE_W-1:0] cause;
        logic [PRI_W-1:0]   pri;
    } stk_entry_t;

    // Slot 0 is the exception vector, slot i+1 is irq i, slot NUM_IRQ+1 is the fatal vector.
    function automatic logic [PC_W-1:0] vec(input int unsigned base,
                                            input int unsigned stride,
                                            input int unsigned slot);
        return PC_W'(base + slot * stride);
    endfunction

endpackage

// File: rtl/irq_exc_ctrl_ctx_stack.sv
// Shift-register LIFO of handler contexts; entry 0 is always the top, vacated slots fill with zero.
module ctx_stack #(
    parameter int DEPTH = 3,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            count <= '0;
        end else if (push && !full) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
            mem[DEPTH-1] <= '0;
            count <= count - CW'(1);
        end
    end

    assign top   = mem[0];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/irq_exc_ctrl.sv
// Interrupt/exception arbiter with a nesting context stack and a one-cycle PC redirect pulse.
module irq_exc_ctrl
    import irq_exc_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ    = 4,
    parameter int          NEST_DEPTH = 3,
    parameter int          ADDR_W     = 32,
    parameter int unsigned VEC_BASE   = 400,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IRQ-1:0]              irq_in,
    input  logic                            mask_we,
    input  logic [NUM_IRQ-1:0]              mask_din,
    input  logic                            exc_valid,
    input  logic [2:0]                      exc_code,
    input  logic [ADDR_W-1:0]               exc_pc,
    input  logic [ADDR_W-1:0]               int_pc,
    input  logic                            eret,
    output logic                            redirect,
    output logic [ADDR_W-1:0]               redirect_pc,
    output logic [ADDR_W-1:0]               epc_out,
    output logic [CAUSE_W-1:0]              cause_out,
    output logic [$clog2(NEST_DEPTH+1)-1:0] depth,
    output logic [NUM_IRQ-1:0]              pending,
    output logic                            stk_err
);

    localparam int DW = $clog2(NEST_DEPTH + 1);

    ctrl_state_t        state, state_n;
    logic [NUM_IRQ-1:0] mask, irq_prev, pend_q, clr;
    logic               redir_q, redir_n, err_q, set_err;
    logic [ADDR_W-1:0]  rpc_q, rpc_n;
    logic               push, pop, full, empty;
    stk_entry_t         push_e, top_e;
    logic [DW-1:0]      count;
    logic [PRI_W-1:0]   cur_pri;
    logic [NUM_IRQ-1:0] elig;
    logic               any_elig;
    logic [2:0]         sel;

    ctx_stack #(
        .DEPTH (NEST_DEPTH),
        .W     ($bits(stk_entry_t))
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_e),
        .top   (top_e),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Exception entries carry pri=NUM_IRQ, so every enabled irq may preempt an exception handler.
    assign cur_pri = empty ? PRI_W'(NUM_IRQ) : top_e.pri;

    always_comb begin
        elig = '0;
        sel  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            elig[i] = pend_q[i] & mask[i] & (PRI_W'(i) < cur_pri);
        end
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) sel = 3'(i);
        end
        any_elig = (|elig) & ~full;
    end

    always_comb begin
        state_n = state;
        redir_n = 1'b0;
        rpc_n   = rpc_q;
        push    = 1'b0;
        pop     = 1'b0;
        push_e  = '0;
        clr     = '0;
        set_err = 1'b0;
        case (state)
            RUN: begin
                // An eret with nothing to return to falls through as if absent.
                if (eret && !empty) begin
                    pop     = 1'b1;
                    redir_n = 1'b1;
                    rpc_n   = top_e.pc[ADDR_W-1:0];
                    state_n = REDIR;
                end else if (exc_valid) begin
                    redir_n = 1'b1;
                    state_n = REDIR;
                    if (!full) begin
                        push         = 1'b1;
                        push_e.pc    = PC_W'(exc_pc);
                        push_e.cause = {1'b0, exc_code};
                        push_e.pri   = PRI_W'(NUM_IRQ);
                        rpc_n        = ADDR_W'(vec(VEC_BASE, VEC_STRIDE, 0));
                    end else begin
                        set_err = 1'b1;
                        rpc_n   = ADDR_W'(vec(VEC_BASE, VEC_STRIDE, NUM_IRQ + 1));
                    end
                end else if (any_elig) begin
                    push         = 1'b1;
                    push_e.pc    = PC_W'(int_pc);
                    push_e.cause = {1'b1, sel};
                    push_e.pri   = {1'b0, sel};
                    clr          = NUM_IRQ'(1) << sel;
                    redir_n      = 1'b1;
                    rpc_n        = ADDR_W'(vec(VEC_BASE, VEC_STRIDE, 32'(sel) + 1));
                    state_n      = REDIR;
                end
            end
            REDIR:   state_n = RUN;
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            mask     <= '0;
            irq_prev <= '0;
            pend_q   <= '0;
            redir_q  <= 1'b0;
            rpc_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            irq_prev <= irq_in;
            pend_q   <= (pend_q | (irq_in & ~irq_prev)) & ~clr;
            redir_q  <= redir_n;
            rpc_q    <= rpc_n;
            if (mask_we) mask  <= mask_din;
            if (set_err) err_q <= 1'b1;
        end
    end

    assign redirect    = redir_q;
    assign redirect_pc = rpc_q;
    assign epc_out     = top_e.pc[ADDR_W-1:0];
    assign cause_out   = top_e.cause;
    assign depth       = count;
    assign pending     = pend_q;
    assign stk_err     = err_q;

endmodule

// File: doc/irq_exc_ctrl.md
Name: irq_exc_ctrl

Overview:
- Parametrised successor to the single-level EPC/Cause pair.
- Arbitrates NUM_IRQ external interrupt lines and synchronous pipeline exceptions (overflow, divzero, break, undefined op).
- Keeps a nesting stack of {EPC, cause, priority} and drives a one-cycle PC redirect/flush to the pipeline's PC mux.
- Sits beside the PC register and control unit; the eret decode in ID pops the stack.

Parameters:
NUM_IRQ, 4, number of interrupt lines (1..8); line 0 has highest priority
NEST_DEPTH, 3, maximum stacked handler contexts (>=1)
ADDR_W, 32, PC width
VEC_BASE, 400, exception vector address
VEC_STRIDE, 4, byte spacing between vectors

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
irq_in  in  NUM_IRQ  raw interrupt levels, already synchronised
mask_we  in  1  write strobe for the interrupt mask
mask_din  in  NUM_IRQ  new mask (1 = enabled)
exc_valid  in  1  synchronous exception in the pipeline this cycle
exc_code  in  3  exception cause code
exc_pc  in  ADDR_W  return PC for the exception
int_pc  in  ADDR_W  resume PC for interrupts (PC+4 held in IF/ID)
eret  in  1  return-from-handler decoded in ID
redirect  out  1  one-cycle pulse: the pipeline loads redirect_pc and flushes IF/ID
redirect_pc  out  ADDR_W  target PC
epc_out  out  ADDR_W  EPC at top of stack (0 when empty)
cause_out  out  4  cause at top of stack; bit3 = interrupt, [2:0] = code or irq index
depth  out  clog2(NEST_DEPTH+1)  current stack occupancy
pending  out  NUM_IRQ  latched pending requests
stk_err  out  1  sticky: exception taken while stack full

Behaviour:
- Reset (synchronous, rst=1 at posedge): all outputs 0. mask=0 (all masked). Pending, stack and edge registers are cleared. State=RUN.
- Edge capture: irq_prev is registered each cycle. A rising edge on a line sets pending[i]. The bit is cleared only when that irq is taken. A new edge on an already-pending line is absorbed.
- Current priority cur_pri:
  - Equals NUM_IRQ when the stack is empty or the top entry is an exception.
  - Otherwise equals the top entry's irq index.
- Eligible irq: pending & mask, index < cur_pri, depth < NEST_DEPTH. The lowest index wins.
- FSM states RUN and REDIR. Decisions are made in RUN only. Priority is eret > exc_valid > eligible irq.
  - eret with depth>0: pop; redirect_pc = popped EPC; go REDIR.
  - eret with depth=0: ignored, no redirect.
  - exc_valid with depth<NEST_DEPTH: push {exc_pc, {0,exc_code}, NUM_IRQ}; redirect_pc = VEC_BASE; go REDIR.
  - exc_valid with depth=NEST_DEPTH: no push; stk_err set; redirect_pc = VEC_BASE + (NUM_IRQ+1)*VEC_STRIDE (fatal vector); go REDIR.
  - Irq i: push {int_pc, {1,i}, i}; clear pending[i]; redirect_pc = VEC_BASE + (i+1)*VEC_STRIDE; go REDIR.
- Latency: redirect and redirect_pc are registered and assert the cycle after the decision inputs are sampled.
- REDIR lasts exactly one cycle with redirect=1, then returns to RUN. Requests arriving during REDIR stay pending. exc_valid and eret present during REDIR are ignored, because the flushed pipeline invalidates them.
- Simultaneous events:
  - A lost irq stays pending.
  - A mask write takes effect the next cycle.
  - Edge capture continues in all states.
- epc_out, cause_out and depth update in the same cycle redirect asserts.
- Reset mid-REDIR: redirect drops in the reset cycle and the stack is emptied.

Decomposition:
- Shared package holds:
  - CAUSE_W=4.
  - Exception code constants: OVF=1, DIVZ=2, BRK=3, UNDEF=4.
  - Vector-address function vec(i).
  - Stack entry struct {pc, cause, pri}.
- One sub-module, ctx_stack: a parametrised LIFO (DEPTH, entry width) with push/pop/full/empty/top. Push and pop are never simultaneous.

Test Plan:
- Reset, then mask=4'b1111, pulse irq_in[2] at cycle 5 with int_pc=0x40 -> redirect at cycle 7, redirect_pc=412, cause_out=4'b1010, epc_out=0x40, depth=1, pending[2]=0.
- Inside irq2, pulse irq_in[3] then irq_in[0] -> irq3 is held pending (lower priority); irq0 is taken with redirect_pc=404 and depth=2. eret -> redirect_pc = irq0's int_pc, depth=1.
- exc_valid with exc_code=1 and irq_in[1] rising in the same cycle, exc_pc=0x80 -> redirect_pc=400, cause_out=4'b0001. irq1 stays pending and is taken after the REDIR cycle with redirect_pc=408.
- Fill the stack to depth 3 with nested irqs, then exc_valid -> redirect_pc=420, stk_err=1, depth stays 3. A further eligible irq is not taken.
- With mask=0, irq edges -> pending set, no redirect. Write mask=4'b0001 -> the irq0 redirect follows two cycles after mask_we.
- eret at depth 0 -> no redirect. Assert rst while REDIR -> next cycle all outputs 0, stk_err cleared.
